// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Multi-cycle unsigned N x N -> 2N shift-and-add multiplier for the ALU.
// It sits beside the combinational ALU path, and the control unit selects it
// for MUL instructions.
//
// A single ripple_adder instance is the only arithmetic element. On each RUN
// cycle it adds the multiplicand (gated by the current multiplier LSB) to the
// high half of the partial product. The {carry_out, sum, lo} word is then
// shifted right by one place, so one multiplier bit is retired per clock.
//
// Ports:
//   clk      in   1    system clock, rising-edge active
//   rst_n    in   1    asynchronous reset, active-low
//   start    in   1    request, sampled on the rising edge of clk
//   a        in   N    multiplicand, unsigned
//   b        in   N    multiplier, unsigned
//   busy     out  1    high while an operation is iterating (state RUN)
//   done     out  1    one-cycle pulse, product is valid (state DONE)
//   product  out  2N   result, held until the next operation completes
//
// Optional feature:
//   MUL_ZERO_BYPASS_EN - when defined, a request with a zero operand goes
//   straight to DONE with product 0, so done follows the accepting edge by
//   one cycle and busy never asserts. When undefined, every request takes
//   the full N iterations.
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [N-1:0]  mcand;
  logic [CW-1:0] count;

  logic [N-1:0]  add_b;
  logic [N-1:0]  add_s;
  logic          add_co;

  // The multiplicand is added only when the multiplier bit now sitting in
  // lo[0] is set. Otherwise the adder just passes hi through unchanged.
  assign add_b = lo[0] ? mcand : '0;

  ripple_adder #(.N(N)) u_adder (
    .a        (hi),
    .b        (add_b),
    .carry_in (1'b0),
    .s        (add_s),
    .carry_out(add_co)
  );

  // busy and done decode the state register only, so no input reaches them
  // combinationally.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Main sequencer and datapath registers. A start is accepted in IDLE and
  // also in DONE, which allows back-to-back operations. A start seen while in
  // RUN is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            count <= '0;
`ifdef MUL_ZERO_BYPASS_EN
            if ((a == '0) || (b == '0)) begin
              state   <= DONE;
              product <= '0;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Shift {carry_out, sum, lo} right by one place. carry_out becomes
          // the new top bit of hi, so no carry is ever lost.
          hi    <= {add_co, add_s[N-1:1]};
          lo    <= {add_s[0], lo[N-1:1]};
          count <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            state   <= DONE;
            product <= {add_co, add_s, lo[N-1:1]};
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// ---------------------------------------------------------------------------
// ripple_adder
//
// N-bit ripple-carry adder. This is the team's shared adder and the single
// arithmetic element used by the multiplier.
//
// Ports:
//   a, b       in   N   addends
//   carry_in   in   1   carry into bit 0
//   s          out  N   sum
//   carry_out  out  1   carry out of bit N-1
// ---------------------------------------------------------------------------
module ripple_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] s,
  output logic         carry_out
);

  logic [N:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign carry_out = c[N];

endmodule
